bs_cmd_pipe: RTL and testbench

Registered command stage wrapped around the combinational barrel_shifter. Accepts shift commands (opsel, amount, data) on a valid/ready handshake and buffers them in a small FIFO. Drives the shifter from the FIFO head and captures each result in an output register with its own valid/ready handshake. Sits between the ALU issue logic (upstream) and writeback (downstream).

---
 rtl/bs_pkg.sv | 20 ++
 rtl/barrel_shifter.sv | 32 +++
 rtl/bs_cmd_pipe.sv | 99 +++++++++
 tb/tb_bs_cmd_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared definitions for the barrel-shifter command pipe: opcodes, command
// record layout and datapath width.
package bs_pkg;

   localparam int DW = 32;

   localparam logic [2:0] OP_SLL      = 3'd0;
   localparam logic [2:0] OP_SRL      = 3'd1;
   localparam logic [2:0] OP_SRA      = 3'd2;
   localparam logic [2:0] OP_ROL      = 3'd3;
   localparam logic [2:0] OP_ROR      = 3'd4;
   localparam logic [2:0] OP_RSVD_MIN = 3'd5;

   typedef struct packed {
      logic [2:0]    opsel;
      logic [4:0]    amount;
      logic [DW-1:0] data;
   } bs_cmd_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 32-bit shifter/rotator; reserved opcodes pass data through
// and raise o_err.
module barrel_shifter
   import bs_pkg::*;
(
   input  logic [2:0]    i_opsel,
   input  logic [4:0]    i_amount,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_result,
   output logic          o_err
);

   logic [5:0] w_inv;

   // Complement shift for rotates; a value of 32 shifts everything out, so
   // amount 0 rotates cleanly to the original data.
   assign w_inv = 6'(DW) - {1'b0, i_amount};

   always_comb begin
      o_result = i_data;
      o_err    = 1'b0;
      case (i_opsel)
         OP_SLL:  o_result = i_data << i_amount;
         OP_SRL:  o_result = i_data >> i_amount;
         OP_SRA:  o_result = DW'($signed(i_data) >>> i_amount);
         OP_ROL:  o_result = (i_data << i_amount) | (i_data >> w_inv);
         OP_ROR:  o_result = (i_data >> i_amount) | (i_data << w_inv);
         default: o_err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/bs_cmd_pipe.sv
// Command FIFO in front of barrel_shifter with a registered, handshaked
// result stage.
module bs_cmd_pipe
   import bs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_opsel,
   input  logic [4:0]    in_amount,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic          out_err,
   output logic [AW:0]   fifo_level,
   output logic          busy
);

   bs_cmd_t        r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_level;
   logic           r_out_valid;
   logic [DW-1:0]  r_out_result;
   logic           r_out_err;

   bs_cmd_t        w_in_cmd;
   bs_cmd_t        w_head;
   logic           w_push;
   logic           w_pop;
   logic           w_slot_free;
   logic [DW-1:0]  w_result;
   logic           w_err;

   assign w_in_cmd    = '{opsel: in_opsel, amount: in_amount, data: in_data};
   assign w_head      = r_mem[r_rd_ptr];

   // in_ready looks only at registered level: a full FIFO refuses input even
   // when a pop happens on the same edge.
   assign in_ready    = (r_level != (AW+1)'(DEPTH));
   assign w_push      = in_valid && in_ready;
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_pop       = (r_level != '0) && w_slot_free;

   barrel_shifter u_shifter (
      .i_opsel  (w_head.opsel),
      .i_amount (w_head.amount),
      .i_data   (w_head.data),
      .o_result (w_result),
      .o_err    (w_err)
   );

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_cmd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_err    <= 1'b0;
      end else if (w_pop) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_result;
         r_out_err    <= w_err;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_err    = r_out_err;
   assign fifo_level = r_level;
   assign busy       = (r_level != '0) || r_out_valid;

endmodule

// File: tb/tb_bs_cmd_pipe.sv
// Directed bench for bs_cmd_pipe: hand-computed vectors checked with
// immediate assertions.
module tb_bs_cmd_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_opsel;
   logic [4:0]  in_amount;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_err;
   logic [2:0]  fifo_level;
   logic        busy;

   int n_vec;
   int n_miss;

   logic [31:0] exp_rot [4];

   bs_cmd_pipe #(.DEPTH(4), .AW(2), .DW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opsel   (in_opsel),
      .in_amount  (in_amount),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .fifo_level (fifo_level),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] d);
      in_valid  = 1'b1;
      in_opsel  = op;
      in_amount = amt;
      in_data   = d;
   endtask

   initial begin
      n_vec     = 0;
      n_miss    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_opsel  = '0;
      in_amount = '0;
      in_data   = '0;
      out_ready = 1'b1;
      exp_rot[0] = 32'h0BADC0DE;
      exp_rot[1] = 32'hFBADC0DE;
      exp_rot[2] = 32'hADC0DE1B;
      exp_rot[3] = 32'h1BADC0DE;

      #1;
      chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
      chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
      chk("rst_out_result", out_result,          32'd0);
      chk("rst_out_err",    {31'd0, out_err},    32'd0);
      chk("rst_level",      {29'd0, fifo_level}, 32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // single SLL
      set_cmd(3'd0, 5'd4, 32'hBADC0DE1);
      tick();
      in_valid = 1'b0;
      chk("sll_latency_valid", {31'd0, out_valid},  32'd0);
      chk("sll_level1",        {29'd0, fifo_level}, 32'd1);
      tick();
      chk("sll_valid",  {31'd0, out_valid}, 32'd1);
      chk("sll_result", out_result,         32'hADC0DE10);
      chk("sll_err",    {31'd0, out_err},   32'd0);

      // back-to-back SRL/SRA/ROL/ROR
      set_cmd(3'd1, 5'd4, 32'hBADC0DE1);
      tick();
      set_cmd(3'd2, 5'd4, 32'hBADC0DE1);
      tick();
      chk("b2b_valid0", {31'd0, out_valid}, 32'd1);
      chk("b2b_res0",   out_result,         exp_rot[0]);
      set_cmd(3'd3, 5'd4, 32'hBADC0DE1);
      tick();
      chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
      chk("b2b_res1",   out_result,         exp_rot[1]);
      set_cmd(3'd4, 5'd4, 32'hBADC0DE1);
      tick();
      chk("b2b_valid2", {31'd0, out_valid}, 32'd1);
      chk("b2b_res2",   out_result,         exp_rot[2]);
      in_valid = 1'b0;
      tick();
      chk("b2b_valid3", {31'd0, out_valid}, 32'd1);
      chk("b2b_res3",   out_result,         exp_rot[3]);
      tick();
      chk("b2b_drained", {31'd0, out_valid}, 32'd0);
      chk("b2b_held",    out_result,         exp_rot[3]);

      // backpressure: five commands, FIFO full, sixth rejected
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_cmd(3'd0, 5'd1, 32'h100 + 32'(k));
         tick();
      end
      chk("bp_level4",   {29'd0, fifo_level}, 32'd4);
      chk("bp_in_ready", {31'd0, in_ready},   32'd0);
      chk("bp_valid",    {31'd0, out_valid},  32'd1);
      chk("bp_res0",     out_result,          32'h200);
      set_cmd(3'd0, 5'd1, 32'h1FF);
      tick();
      chk("bp_reject_level", {29'd0, fifo_level}, 32'd4);
      chk("bp_hold_res",     out_result,          32'h200);
      chk("bp_hold_err",     {31'd0, out_err},    32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 1; k < 5; k++) begin
         tick();
         chk("bp_drain_res",   out_result,          32'h200 + 32'(2 * k));
         chk("bp_drain_level", {29'd0, fifo_level}, 32'(4 - k));
      end
      tick();
      chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_empty_busy",  {31'd0, busy},      32'd0);

      // reserved opsel then normal SLL
      set_cmd(3'd6, 5'd7, 32'h12345678);
      tick();
      set_cmd(3'd0, 5'd1, 32'h00000001);
      tick();
      chk("rsvd_result", out_result,       32'h12345678);
      chk("rsvd_err",    {31'd0, out_err}, 32'd1);
      in_valid = 1'b0;
      tick();
      chk("post_rsvd_result", out_result,       32'h2);
      chk("post_rsvd_err",    {31'd0, out_err}, 32'd0);

      // amount 0 for every valid opsel
      for (int k = 0; k < 5; k++) begin
         set_cmd(3'(k), 5'd0, 32'h80000001);
         tick();
         in_valid = 1'b0;
         tick();
         chk("amt0_result", out_result,       32'h80000001);
         chk("amt0_err",    {31'd0, out_err}, 32'd0);
      end
      tick();

      // async reset with 3 buffered commands and a pending result
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_cmd(3'd0, 5'd2, 32'h10 + 32'(k));
         tick();
      end
      in_valid = 1'b0;
      chk("pre_rst_level", {29'd0, fifo_level}, 32'd3);
      chk("pre_rst_valid", {31'd0, out_valid},  32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid",  {31'd0, out_valid},  32'd0);
      chk("async_rst_level",  {29'd0, fifo_level}, 32'd0);
      chk("async_rst_busy",   {31'd0, busy},       32'd0);
      chk("async_rst_result", out_result,          32'd0);
      chk("async_rst_ready",  {31'd0, in_ready},   32'd1);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      set_cmd(3'd0, 5'd8, 32'h000000A5);
      tick();
      in_valid = 1'b0;
      tick();
      chk("post_rst_valid",  {31'd0, out_valid}, 32'd1);
      chk("post_rst_result", out_result,         32'h0000A500);
      chk("post_rst_err",    {31'd0, out_err},   32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
